// File: rtl/saber_seq_pkg.sv
// Shared definitions for the Saber unit sequencer: FSM encoding, unit indices, default widths.
package saber_seq_pkg;

   localparam int unsigned SEQ_ADDR_W = 9;
   localparam int unsigned SEQ_DATA_W = 64;
   localparam int unsigned CYC_W      = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2,
      ST_FIN  = 2'd3
   } seq_state_t;

   // Slot assignment of the functional units in the unit bank
   localparam logic [2:0] UNIT_ADD_M_PACK = 3'd0;
   localparam logic [2:0] UNIT_POLY_MUL   = 3'd1;
   localparam logic [2:0] UNIT_SHA3       = 3'd2;
   localparam logic [2:0] UNIT_VERIFY     = 3'd3;

endpackage

// File: rtl/saber_addr_xlate.sv
// Rebases a unit-local address onto one of two BRAM bases; the sum wraps at 2^ADDR_W.
module saber_addr_xlate
   import saber_seq_pkg::*;
#(
   parameter int unsigned ADDR_W = SEQ_ADDR_W
) (
   input  logic              sel,
   input  logic [ADDR_W-1:0] base0,
   input  logic [ADDR_W-1:0] base1,
   input  logic [ADDR_W-1:0] offset,
   output logic [ADDR_W-1:0] addr
);

   assign addr = (sel ? base1 : base0) + offset;

endmodule

// File: rtl/saber_unit_sequencer.sv
// Launches one Saber functional unit per command, shares the BRAM ports with it,
// and reports completion with a RUN cycle count or a timeout/bad-index error.
module saber_unit_sequencer
   import saber_seq_pkg::*;
#(
   parameter int unsigned NUM_UNITS   = 4,
   parameter int unsigned ADDR_W      = SEQ_ADDR_W,
   parameter int unsigned DATA_W      = SEQ_DATA_W,
   parameter int unsigned TIMEOUT_CYC = 4096
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        cmd_valid,
   output logic                        cmd_ready,
   input  logic [2:0]                  cmd_unit,
   input  logic [ADDR_W-1:0]           cmd_rd_base0,
   input  logic [ADDR_W-1:0]           cmd_rd_base1,
   input  logic [ADDR_W-1:0]           cmd_wr_base,
   output logic                        cmd_done,
   output logic                        cmd_err,
   output logic [CYC_W-1:0]            cmd_cycles,
   output logic                        busy,
   output logic [NUM_UNITS-1:0]        unit_rst,
   input  logic [NUM_UNITS-1:0]        unit_done,
   input  logic [NUM_UNITS-1:0]        unit_rd_base_sel,
   input  logic [NUM_UNITS*ADDR_W-1:0] unit_rd_addr,
   input  logic [NUM_UNITS*ADDR_W-1:0] unit_wr_addr,
   input  logic [NUM_UNITS*DATA_W-1:0] unit_wr_data,
   input  logic [NUM_UNITS-1:0]        unit_wr_en,
   output logic [ADDR_W-1:0]           mem_rd_addr,
   output logic [ADDR_W-1:0]           mem_wr_addr,
   output logic [DATA_W-1:0]           mem_wr_data,
   output logic                        mem_wr_en
);

   seq_state_t        state;
   logic [2:0]        sel_q;
   logic              bad_q;
   logic [ADDR_W-1:0] rd_base0_q;
   logic [ADDR_W-1:0] rd_base1_q;
   logic [ADDR_W-1:0] wr_base_q;
   logic [CYC_W-1:0]  cnt;
   logic [CYC_W-1:0]  cnt_next;

   logic              sel_done;
   logic              sel_rd_base_sel;
   logic [ADDR_W-1:0] sel_rd_addr;
   logic [ADDR_W-1:0] sel_wr_addr;
   logic [DATA_W-1:0] sel_wr_data;
   logic              sel_wr_en;

   // Port mux for the selected unit; an out-of-range index selects nothing
   always_comb begin
      sel_done        = 1'b0;
      sel_rd_base_sel = 1'b0;
      sel_rd_addr     = '0;
      sel_wr_addr     = '0;
      sel_wr_data     = '0;
      sel_wr_en       = 1'b0;
      for (int unsigned i = 0; i < NUM_UNITS; i++) begin
         if (sel_q == 3'(i)) begin
            sel_done        = unit_done[i];
            sel_rd_base_sel = unit_rd_base_sel[i];
            sel_rd_addr     = unit_rd_addr[i*ADDR_W +: ADDR_W];
            sel_wr_addr     = unit_wr_addr[i*ADDR_W +: ADDR_W];
            sel_wr_data     = unit_wr_data[i*DATA_W +: DATA_W];
            sel_wr_en       = unit_wr_en[i];
         end
      end
   end

   saber_addr_xlate #(.ADDR_W(ADDR_W)) u_rd_xlate (
      .sel    (sel_rd_base_sel),
      .base0  (rd_base0_q),
      .base1  (rd_base1_q),
      .offset (sel_rd_addr),
      .addr   (mem_rd_addr)
   );

   saber_addr_xlate #(.ADDR_W(ADDR_W)) u_wr_xlate (
      .sel    (1'b0),
      .base0  (wr_base_q),
      .base1  (wr_base_q),
      .offset (sel_wr_addr),
      .addr   (mem_wr_addr)
   );

   // Combinational path keeps the unit's own one-cycle BRAM read latency
   assign mem_wr_data = sel_wr_data;
   assign mem_wr_en   = (state == ST_RUN) && sel_wr_en;
   assign cnt_next    = cnt + CYC_W'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         cmd_ready  <= 1'b1;
         busy       <= 1'b0;
         cmd_done   <= 1'b0;
         cmd_err    <= 1'b0;
         cmd_cycles <= '0;
         unit_rst   <= '1;
         cnt        <= '0;
         sel_q      <= '0;
         bad_q      <= 1'b0;
         rd_base0_q <= '0;
         rd_base1_q <= '0;
         wr_base_q  <= '0;
      end else begin
         cmd_done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (cmd_valid) begin
                  sel_q      <= cmd_unit;
                  bad_q      <= 32'(cmd_unit) >= NUM_UNITS;
                  rd_base0_q <= cmd_rd_base0;
                  rd_base1_q <= cmd_rd_base1;
                  wr_base_q  <= cmd_wr_base;
                  cmd_ready  <= 1'b0;
                  busy       <= 1'b1;
                  state      <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               cnt <= '0;
               if (bad_q) begin
                  cmd_done   <= 1'b1;
                  cmd_err    <= 1'b1;
                  cmd_cycles <= '0;
                  state      <= ST_FIN;
               end else begin
                  unit_rst <= ~(NUM_UNITS'(1) << sel_q);
                  state    <= ST_RUN;
               end
            end
            ST_RUN: begin
               cnt <= cnt_next;
               // Done takes priority over a coincident timeout
               if (sel_done || (cnt_next == CYC_W'(TIMEOUT_CYC))) begin
                  cmd_done   <= 1'b1;
                  cmd_err    <= ~sel_done;
                  cmd_cycles <= cnt_next;
                  unit_rst   <= '1;
                  state      <= ST_FIN;
               end
            end
            ST_FIN: begin
               cmd_ready <= 1'b1;
               busy      <= 1'b0;
               state     <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_saber_unit_sequencer.sv
// Directed bench: a long-timeout instance and a TIMEOUT_CYC=16 instance share one stimulus stream.
module tb_saber_unit_sequencer;
   import saber_seq_pkg::*;

   localparam int unsigned NU = 4;
   localparam int unsigned AW = 9;
   localparam int unsigned DW = 64;

   logic              clk = 1'b0;
   logic              rst;
   logic              cmd_valid;
   logic [2:0]        cmd_unit;
   logic [AW-1:0]     cmd_rd_base0, cmd_rd_base1, cmd_wr_base;
   logic [NU-1:0]     unit_done, unit_rd_base_sel, unit_wr_en;
   logic [NU*AW-1:0]  unit_rd_addr, unit_wr_addr;
   logic [NU*DW-1:0]  unit_wr_data;

   logic              a_cmd_ready, a_cmd_done, a_cmd_err, a_busy, a_mem_wr_en;
   logic [15:0]       a_cmd_cycles;
   logic [NU-1:0]     a_unit_rst;
   logic [AW-1:0]     a_mem_rd_addr, a_mem_wr_addr;
   logic [DW-1:0]     a_mem_wr_data;
   logic              t_cmd_ready, t_cmd_done, t_cmd_err, t_busy, t_mem_wr_en;
   logic [15:0]       t_cmd_cycles;
   logic [NU-1:0]     t_unit_rst;
   logic [AW-1:0]     t_mem_rd_addr, t_mem_wr_addr;
   logic [DW-1:0]     t_mem_wr_data;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   saber_unit_sequencer #(.NUM_UNITS(NU), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(4096)) dut_a (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(a_cmd_ready), .cmd_unit(cmd_unit),
      .cmd_rd_base0(cmd_rd_base0), .cmd_rd_base1(cmd_rd_base1), .cmd_wr_base(cmd_wr_base),
      .cmd_done(a_cmd_done), .cmd_err(a_cmd_err), .cmd_cycles(a_cmd_cycles), .busy(a_busy),
      .unit_rst(a_unit_rst), .unit_done(unit_done), .unit_rd_base_sel(unit_rd_base_sel),
      .unit_rd_addr(unit_rd_addr), .unit_wr_addr(unit_wr_addr), .unit_wr_data(unit_wr_data),
      .unit_wr_en(unit_wr_en), .mem_rd_addr(a_mem_rd_addr), .mem_wr_addr(a_mem_wr_addr),
      .mem_wr_data(a_mem_wr_data), .mem_wr_en(a_mem_wr_en)
   );

   saber_unit_sequencer #(.NUM_UNITS(NU), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(16)) dut_t (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(t_cmd_ready), .cmd_unit(cmd_unit),
      .cmd_rd_base0(cmd_rd_base0), .cmd_rd_base1(cmd_rd_base1), .cmd_wr_base(cmd_wr_base),
      .cmd_done(t_cmd_done), .cmd_err(t_cmd_err), .cmd_cycles(t_cmd_cycles), .busy(t_busy),
      .unit_rst(t_unit_rst), .unit_done(unit_done), .unit_rd_base_sel(unit_rd_base_sel),
      .unit_rd_addr(unit_rd_addr), .unit_wr_addr(unit_wr_addr), .unit_wr_data(unit_wr_data),
      .unit_wr_en(unit_wr_en), .mem_rd_addr(t_mem_rd_addr), .mem_wr_addr(t_mem_wr_addr),
      .mem_wr_data(t_mem_wr_data), .mem_wr_en(t_mem_wr_en)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Waits (bounded) for both instances to be idle, then presents one command for one cycle
   task automatic issue(input logic [2:0] u, input logic [AW-1:0] b0, input logic [AW-1:0] b1,
                        input logic [AW-1:0] wb);
      int n = 0;
      while (!(a_cmd_ready && t_cmd_ready) && n < 100) begin
         step();
         n++;
      end
      chk("accept_ready", 64'({a_cmd_ready, t_cmd_ready}), 64'h3);
      cmd_unit     = u;
      cmd_rd_base0 = b0;
      cmd_rd_base1 = b1;
      cmd_wr_base  = wb;
      cmd_valid    = 1'b1;
      step();
      cmd_valid    = 1'b0;
   endtask

   initial begin
      rst = 1'b1; cmd_valid = 1'b0; cmd_unit = '0;
      cmd_rd_base0 = '0; cmd_rd_base1 = '0; cmd_wr_base = '0;
      unit_done = '0; unit_rd_base_sel = '0; unit_wr_en = '0;
      unit_rd_addr = '0; unit_wr_addr = '0; unit_wr_data = '0;
      for (int i = 0; i < int'(NU); i++) unit_wr_data[i*DW +: DW] = 64'hA5A5_0000_0000_0000 + 64'(i);

      // Reset
      step(); step();
      chk("rst_ready", 64'(a_cmd_ready), 64'd1);
      chk("rst_busy", 64'(a_busy), 64'd0);
      chk("rst_unit_rst", 64'(a_unit_rst), 64'hF);
      chk("rst_wr_en", 64'(a_mem_wr_en), 64'd0);
      chk("rst_done", 64'(a_cmd_done), 64'd0);
      chk("rst_cycles", 64'(a_cmd_cycles), 64'd0);
      rst = 1'b0;
      step();

      // Normal command on unit 1: accepted at T, now in T+1 (LOAD)
      issue(UNIT_POLY_MUL, 9'h040, 9'h1F0, 9'h100);
      unit_wr_addr[1*AW +: AW] = 9'd2;
      unit_wr_en[1] = 1'b1;
      #1;
      chk("load_unit_rst", 64'(a_unit_rst), 64'hF);
      chk("load_busy", 64'({a_busy, a_cmd_ready}), 64'b10);
      chk("load_wr_gate", 64'(a_mem_wr_en), 64'd0);
      step();
      unit_rd_addr[1*AW +: AW] = 9'd5;
      unit_rd_base_sel[1] = 1'b0;
      #1;
      chk("run_unit_rst", 64'(a_unit_rst), 64'b1101);
      chk("run_rd_sel0", 64'(a_mem_rd_addr), 64'h045);
      chk("run_wr_addr", 64'(a_mem_wr_addr), 64'h102);
      chk("run_wr_en", 64'(a_mem_wr_en), 64'd1);
      chk("run_wr_data", a_mem_wr_data, 64'hA5A5_0000_0000_0001);
      step();
      unit_rd_addr[1*AW +: AW] = 9'd3;
      unit_rd_base_sel[1] = 1'b1;
      unit_wr_en[1] = 1'b0;
      #1;
      chk("run_rd_sel1", 64'(a_mem_rd_addr), 64'h1F3);
      chk("run_wr_en_off", 64'(a_mem_wr_en), 64'd0);
      for (int k = 3; k <= 20; k++) step();
      unit_done[1] = 1'b1;
      #1;
      chk("norm_done_early", 64'(a_cmd_done), 64'd0);
      step();
      unit_done[1] = 1'b0;
      chk("norm_done", 64'(a_cmd_done), 64'd1);
      chk("norm_err", 64'(a_cmd_err), 64'd0);
      chk("norm_cycles", 64'(a_cmd_cycles), 64'd20);
      chk("norm_fin_rst", 64'(a_unit_rst), 64'hF);
      step();
      chk("norm_idle_ready", 64'(a_cmd_ready), 64'd1);
      chk("norm_done_pulse", 64'(a_cmd_done), 64'd0);
      chk("norm_cycles_hold", 64'(a_cmd_cycles), 64'd20);

      // Wrap and isolation on unit 0, done in first RUN cycle
      issue(UNIT_ADD_M_PACK, 9'h1FE, 9'h000, 9'h000);
      step();
      unit_rd_addr[0*AW +: AW] = 9'd5;
      unit_rd_base_sel[0] = 1'b0;
      unit_wr_en[0] = 1'b0;
      unit_wr_en[3] = 1'b1;
      unit_done[0] = 1'b1;
      #1;
      chk("wrap_rd", 64'(a_mem_rd_addr), 64'h003);
      chk("iso_wr_en", 64'(a_mem_wr_en), 64'd0);
      chk("iso_wr_data", a_mem_wr_data, 64'hA5A5_0000_0000_0000);
      chk("wrap_unit_rst", 64'(a_unit_rst), 64'b1110);
      step();
      unit_done[0] = 1'b0;
      unit_wr_en[3] = 1'b0;
      chk("min_done", 64'({a_cmd_done, a_cmd_err}), 64'b10);
      chk("min_cycles", 64'(a_cmd_cycles), 64'd1);
      step();
      chk("min_turnaround_ready", 64'(a_cmd_ready), 64'd1);

      // Timeout on the short-timeout instance, unit 2 never done
      issue(UNIT_SHA3, 9'h000, 9'h000, 9'h000);
      for (int k = 0; k < 16; k++) step();
      chk("to_not_yet", 64'(t_cmd_done), 64'd0);
      chk("to_run_rst", 64'(t_unit_rst), 64'b1011);
      step();
      chk("to_done", 64'(t_cmd_done), 64'd1);
      chk("to_err", 64'(t_cmd_err), 64'd1);
      chk("to_cycles", 64'(t_cmd_cycles), 64'd16);
      chk("to_unit_rst", 64'(t_unit_rst), 64'hF);
      rst = 1'b1;
      step();
      rst = 1'b0;

      // Done and timeout in the same cycle
      issue(UNIT_POLY_MUL, 9'h000, 9'h000, 9'h000);
      for (int k = 0; k < 16; k++) step();
      unit_done[1] = 1'b1;
      step();
      unit_done[1] = 1'b0;
      chk("coll_done", 64'(t_cmd_done), 64'd1);
      chk("coll_err", 64'(t_cmd_err), 64'd0);
      chk("coll_cycles", 64'(t_cmd_cycles), 64'd16);
      chk("coll_long_cycles", 64'({a_cmd_done, a_cmd_err, a_cmd_cycles}), {46'd0, 2'b10, 16'd16});

      // Bad index
      issue(3'd5, 9'h000, 9'h000, 9'h000);
      chk("bad_load_rst", 64'(a_unit_rst), 64'hF);
      chk("bad_load_done", 64'(a_cmd_done), 64'd0);
      step();
      chk("bad_done", 64'({a_cmd_done, a_cmd_err}), 64'b11);
      chk("bad_cycles", 64'(a_cmd_cycles), 64'd0);
      chk("bad_unit_rst", 64'(a_unit_rst), 64'hF);

      // Reset abort in the 3rd RUN cycle
      issue(UNIT_POLY_MUL, 9'h000, 9'h000, 9'h000);
      step(); step(); step();
      rst = 1'b1;
      unit_done[1] = 1'b1;
      step();
      rst = 1'b0;
      chk("abort_ready", 64'({a_cmd_ready, a_busy}), 64'b10);
      chk("abort_unit_rst", 64'(a_unit_rst), 64'hF);
      chk("abort_no_done", 64'(a_cmd_done), 64'd0);
      for (int k = 0; k < 3; k++) begin
         step();
         chk("abort_quiet", 64'({a_cmd_done, t_cmd_done}), 64'd0);
      end
      unit_done[1] = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/saber_unit_sequencer.md
# saber_unit_sequencer

Command-driven sequencer that launches one Saber functional unit at a time (Add_m_pack-style blocks driven by `rst`/`done`) and shares the coprocessor's single BRAM read port and write port among them. For each command it:
- holds every idle unit in reset and releases only the selected unit;
- rebases the unit's local read and write addresses onto command-supplied BRAM bases;
- waits for the unit's `done`, with a watchdog;
- returns a completion pulse with a cycle count.

It sits between the instruction decoder and the unit bank.

## Interface
Parameters:
- NUM_UNITS, 4, number of attached units (≤ 8)
- ADDR_W, 9, BRAM address width
- DATA_W, 64, BRAM word width
- TIMEOUT_CYC, 4096, maximum number of RUN cycles before abort (1..65535)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer idle, command accepted on valid&ready
- cmd_unit  in  3  unit index
- cmd_rd_base0  in  ADDR_W  read base used when unit read_base_sel=0
- cmd_rd_base1  in  ADDR_W  read base used when unit read_base_sel=1
- cmd_wr_base  in  ADDR_W  write base
- cmd_done  out  1  one-cycle completion pulse
- cmd_err  out  1  valid with cmd_done: timeout or bad index
- cmd_cycles  out  16  RUN cycle count, valid with cmd_done, held until next completion
- busy  out  1  not IDLE
- unit_rst  out  NUM_UNITS  per-unit reset
- unit_done  in  NUM_UNITS  per-unit done
- unit_rd_base_sel  in  NUM_UNITS  per-unit base select
- unit_rd_addr  in  NUM_UNITS*ADDR_W  flattened local read addresses
- unit_wr_addr  in  NUM_UNITS*ADDR_W  flattened local write addresses
- unit_wr_data  in  NUM_UNITS*DATA_W  flattened write data
- unit_wr_en  in  NUM_UNITS  per-unit write enable
- mem_rd_addr  out  ADDR_W  BRAM read address
- mem_wr_addr  out  ADDR_W  BRAM write address
- mem_wr_data  out  DATA_W  BRAM write data
- mem_wr_en  out  1  BRAM write enable

BRAM read data is broadcast to all units outside this block.

## Operation
- FSM states IDLE, LOAD, RUN, FIN.
- **IDLE:**
  - cmd_ready=1, all unit_rst=1.
  - On valid&ready, register unit index, bases and a bad flag (cmd_unit ≥ NUM_UNITS), then go to LOAD.
- **LOAD:**
  - all unit_rst=1; clear the cycle counter.
  - If bad, go to FIN with err=1; otherwise go to RUN.
- **RUN:**
  - unit_rst[sel]=0, all others =1; the counter increments every RUN cycle.
  - unit_done[sel] sampled high: go to FIN, err=0.
  - Else, counter reaches TIMEOUT_CYC: go to FIN, err=1.
  - Done and timeout in the same cycle: done wins, err=0.
- **FIN:**
  - cmd_done=1; cmd_err and cmd_cycles are valid.
  - all unit_rst=1; next state IDLE.
- **Address translation** is combinational, so the unit keeps 1-cycle BRAM read latency:
  - mem_rd_addr = (rd_base_sel[sel] ? base1 : base0) + rd_addr[sel]
  - mem_wr_addr = wr_base + wr_addr[sel]
  - Both sums are modulo 2^ADDR_W, so they wrap.
- **Write gating:**
  - mem_wr_en = unit_wr_en[sel] only while in RUN; it is 0 in every other state.
  - Write enables from non-selected units are ignored.
  - mem_wr_data = unit_wr_data[sel].
- **Outside RUN**, mem_rd_addr and mem_wr_addr still show unit sel's translated addresses; they are don't-care.
- **cmd_cycles:**
  - counts RUN cycles, inclusive of the cycle in which done is sampled;
  - equals TIMEOUT_CYC on timeout;
  - equals 0 for a bad index.
- cmd_valid while busy is ignored; the requester holds it.

## Timing
- **Reset values:**
  - cmd_ready=1, busy=0, cmd_done=0, cmd_err=0, cmd_cycles=0;
  - unit_rst all 1, mem_wr_en=0, state IDLE.
- **rst mid-operation:** the next cycle is IDLE with all unit_rst high. The aborted command produces no cmd_done.
- **Command accepted at cycle T:**
  - T+1 LOAD;
  - first RUN cycle T+2 (unit leaves reset);
  - unit_done seen at cycle D → FIN at D+1, cmd_done at D+1;
  - IDLE and cmd_ready at D+2.
- **Minimum turnaround** is 4 cycles from acceptance to the next acceptance (unit done in its first RUN cycle).
- **Bad index:** cmd_done at T+2, with cmd_err=1.

## Structure
- Shared package `saber_seq_pkg` holds:
  - state encoding (IDLE=0, LOAD=1, RUN=2, FIN=3);
  - unit index constants (ADD_M_PACK etc.);
  - default ADDR_W and DATA_W.
- One sub-module, `saber_addr_xlate`: the base-select plus wrap-around adder, instantiated for the read and write paths.
- Port muxing and the FSM live in the top module.

## Test plan
All scenarios use NUM_UNITS=4 and a behavioural unit model.
- **Reset:** drive rst for 2 cycles → cmd_ready=1, busy=0, unit_rst=4'b1111, mem_wr_en=0, cmd_done=0.
- **Normal command:**
  - Stimulus: unit 1, base0=0x040, base1=0x1F0, wr_base=0x100. The model issues rd 5/sel0, rd 3/sel1 and wr 2, then asserts done on its 20th RUN cycle.
  - Required: mem_rd_addr 0x045 then 0x1F3; mem_wr_addr 0x102 with mem_wr_en=1; unit_rst=4'b1101 during RUN.
  - Required: cmd_done at T+22 with cmd_cycles=20, cmd_err=0.
- **Wrap and isolation:**
  - Stimulus: base0=0x1FE and rd_addr 5; meanwhile unit 3 asserts wr_en.
  - Required: mem_rd_addr=0x003; mem_wr_en stays 0.
- **Timeout:**
  - Stimulus: TIMEOUT_CYC=16 and the unit never asserts done.
  - Required: cmd_done at T+18, cmd_err=1, cmd_cycles=16; unit_rst returns to 4'b1111.
- **Done/timeout collision:** with TIMEOUT_CYC=16, done on the 16th RUN cycle → cmd_err=0, cmd_cycles=16.
- **Bad index and reset abort:**
  - Bad index: cmd_unit=5 → cmd_done at T+2 with cmd_err=1, cmd_cycles=0; unit_rst is all 1 throughout.
  - Reset abort: rst in the 3rd RUN cycle → IDLE next cycle, and no cmd_done appears.
